// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared cache geometry and flush sequencer state encodings
package mem_pkg;

   localparam int CACHE_ADRW  = 8;
   localparam int CACHE_LINES = 256;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_DRAIN = 3'd1,
      S_FLUSH = 3'd2,
      S_SWAP  = 3'd3,
      S_DONE  = 3'd4
   } flush_state_t;

endpackage

// File: rtl/flush_counter.sv
// rtl/flush_counter.sv - cacheram index walker with synchronous clear and last-index flag
module flush_counter
   import mem_pkg::*;
#(
   parameter int ADRW  = CACHE_ADRW,
   parameter int LINES = CACHE_LINES
) (
   input  logic            ph1,
   input  logic            reset,
   input  logic            i_clr,
   input  logic            i_en,
   output logic [ADRW-1:0] o_count,
   output logic            o_last
);

   localparam logic [ADRW-1:0] LAST_IDX = ADRW'(LINES - 1);

   logic [ADRW-1:0] r_count;

   // Free wrap at the last index leaves the counter at 0 for the next walk.
   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= r_count + ADRW'(1);
      end
   end

   assign o_count = r_count;
   assign o_last  = (r_count == LAST_IDX);

endmodule

// File: rtl/cache_flush_ctrl.sv
// rtl/cache_flush_ctrl.sv - drain, invalidate both caches, optionally swap swc; FLUSH_ON_RESET_EN adds a boot flush
module cache_flush_ctrl
   import mem_pkg::*;
#(
   parameter int ADRW  = CACHE_ADRW,
   parameter int LINES = CACHE_LINES
) (
   input  logic            ph1,
   input  logic            reset,
   input  logic            flushreq,
   input  logic            swcreq,
   input  logic            swcnext,
   input  logic            wbempty,
   input  logic            icachebusy,
   input  logic            dcachebusy,
   output logic            stall,
   output logic [ADRW-1:0] invadr,
   output logic            invwe,
   output logic            swc,
   output logic            busy,
   output logic            done
);

   flush_state_t r_state;
   flush_state_t w_state_next;

   logic r_swc;
   logic r_swappend;
   logic r_swcval;
   logic r_pending;
   logic r_pendswap;
   logic r_pendswcval;

   logic            w_req;
   logic            w_ready;
   logic            w_boot;
   logic            w_accept;
   logic            w_reload;
   logic            w_cnt_clr;
   logic            w_cnt_en;
   logic            w_cnt_last;
   logic [ADRW-1:0] w_count;

   assign w_req   = flushreq | swcreq;
   assign w_ready = wbempty & ~icachebusy & ~dcachebusy;

`ifdef FLUSH_ON_RESET_EN
   logic r_boot;

   // Acts as a one-shot flush request on the first cycle after reset release.
   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         r_boot <= 1'b1;
      end else begin
         r_boot <= 1'b0;
      end
   end

   assign w_boot = r_boot;
`else
   assign w_boot = 1'b0;
`endif

   flush_counter #(
      .ADRW  (ADRW),
      .LINES (LINES)
   ) u_counter (
      .ph1     (ph1),
      .reset   (reset),
      .i_clr   (w_cnt_clr),
      .i_en    (w_cnt_en),
      .o_count (w_count),
      .o_last  (w_cnt_last)
   );

   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_reload     = 1'b0;
      w_cnt_clr    = 1'b0;
      w_cnt_en     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req | w_boot) begin
               w_state_next = S_DRAIN;
               w_accept     = 1'b1;
            end
         end
         S_DRAIN: begin
            if (w_ready) begin
               w_state_next = S_FLUSH;
               w_cnt_clr    = 1'b1;
            end
         end
         S_FLUSH: begin
            w_cnt_en = 1'b1;
            if (w_cnt_last) begin
               w_state_next = r_swappend ? S_SWAP : S_DONE;
            end
         end
         S_SWAP: begin
            w_state_next = S_DONE;
         end
         S_DONE: begin
            // A request landing in the DONE cycle itself is folded into the reload.
            if (r_pending | w_req) begin
               w_state_next = S_DRAIN;
               w_reload     = 1'b1;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge ph1 or negedge reset) begin
      if (!reset) begin
         r_swc        <= 1'b0;
         r_swappend   <= 1'b0;
         r_swcval     <= 1'b0;
         r_pending    <= 1'b0;
         r_pendswap   <= 1'b0;
         r_pendswcval <= 1'b0;
      end else begin
         if (w_accept) begin
            r_swappend <= swcreq;
            if (swcreq) begin
               r_swcval <= swcnext;
            end
         end else if (w_reload) begin
            r_swappend <= r_pendswap | swcreq;
            r_swcval   <= swcreq ? swcnext : r_pendswcval;
         end

         if (w_reload) begin
            r_pending  <= 1'b0;
            r_pendswap <= 1'b0;
         end else if ((r_state != S_IDLE) && w_req) begin
            r_pending  <= 1'b1;
            r_pendswap <= r_pendswap | swcreq;
            if (swcreq) begin
               r_pendswcval <= swcnext;
            end
         end

         if (r_state == S_SWAP) begin
            r_swc <= r_swcval;
         end
      end
   end

   assign busy   = (r_state != S_IDLE);
   assign stall  = busy | ((w_req | w_boot) & reset);
   assign invwe  = (r_state == S_FLUSH);
   assign invadr = w_count;
   assign done   = (r_state == S_DONE);
   assign swc    = r_swc;

endmodule

// File: doc/cache_flush_ctrl.md
Name: cache_flush_ctrl

Overview:
- Sequencer that invalidates every line of both caches (icache, dcache) and performs a safe cache swap (swc toggle) for the cache controller.
- Before touching tags it drains the write buffer and waits for both cache FSMs to be idle.
- It then walks every cacheram index, writing valid=0, and finally updates swc.
- Stalls the pipeline for the whole sequence.

Parameters:
- ADRW, 8, cacheram index width.
- LINES, 256, number of lines per cache (2**ADRW).

Ports:
- ph1  in  1  single system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- flushreq  in  1  request: invalidate both caches.
- swcreq  in  1  request: invalidate both caches, then load swc from swcnext.
- swcnext  in  1  requested swc value; sampled when swcreq is accepted.
- wbempty  in  1  write buffer has no valid entries and is not writing memory.
- icachebusy  in  1  icache FSM not in its ready state.
- dcachebusy  in  1  dcache FSM not in its ready state.
- stall  out  1  hold fetch/memory stages.
- invadr  out  ADRW  cacheram index being invalidated.
- invwe  out  1  write {valid=0} to both cacherams at invadr this cycle.
- swc  out  1  registered cache-swap select to the cache controller.
- busy  out  1  sequence in progress (state != IDLE).
- done  out  1  one-cycle pulse at end of sequence.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, swc=0, pending=0, swappend=0.
  - stall=0, invwe=0, invadr=0, busy=0, done=0.
  - Reset mid-sequence aborts immediately; after reset release no flush resumes (unless FLUSH_ON_RESET_EN).
- States, with encodings:
  - IDLE (0): if flushreq|swcreq, go to DRAIN. swappend<=swcreq; swcval<=swcnext when swcreq. stall is driven combinationally high in the accepting cycle.
  - DRAIN (1): wait for wbempty & ~icachebusy & ~dcachebusy, then go to FLUSH with counter=0. No timeout.
  - FLUSH (2): invwe=1, invadr=counter, counter+1 each cycle. When counter==LINES-1, go to SWAP if swappend, else DONE. Counter wraps to 0 on exit.
  - SWAP (3): swc<=swcval; go to DONE. Only state that writes swc.
  - DONE (4): done=1 for one cycle. Go to DRAIN if pending (pending cleared, swappend/swcval reloaded from pending copies), else IDLE.
- Outputs by state:
  - stall=1 and busy=1 in every non-IDLE state.
  - invwe is 0 outside FLUSH.
  - invadr holds counter in every state.
- Simultaneous flushreq & swcreq: treated as swcreq (swap includes flush).
- Requests while busy are ORed into pending/pendswap, never dropped; pendswcval takes the last swcnext seen with swcreq.
- swcreq with swcnext==swc: full flush still executed; swc unchanged.
- Latency: with DRAIN satisfied on entry, done rises LINES+2 cycles after the accept cycle (LINES+3 with swap). Each DRAIN wait cycle adds 1.
- Counter width is ADRW; no wider arithmetic; LINES-1 compare is a constant.

Optional Feature:
- Macro: FLUSH_ON_RESET_EN.
- Defined: on reset release, state enters DRAIN with swappend=0, giving an automatic full invalidate. stall=1 from the first post-reset cycle; done pulses at the end. This covers cacheram having no reset.
- Undefined: state=IDLE after reset; valid bits are cleared only by explicit flushreq/swcreq.

Decomposition:
- Shared package mem_pkg holds:
  - state encodings S_IDLE..S_DONE (3-bit);
  - CACHE_ADRW=8 and CACHE_LINES=256, used by cache, cacheram and this block.
- One natural sub-module: flush_counter (ADRW-bit enabled counter with synchronous clear and last-index flag).
- FSM and request latching stay in the top.

Test Plan:
- Reset, flushreq=1 for one cycle, wbempty=1, busy inputs 0 -> invwe high 256 cycles with invadr 0..255, done at cycle 258 after request, swc stays 0, stall low after done.
- swcreq=1, swcnext=1, wbempty held 0 for 10 cycles -> invwe stays 0 during DRAIN; flush starts the cycle after wbempty=1; swc=1 after SWAP; done one cycle later.
- flushreq pulsed at invadr=100 during a flush -> first sequence completes; a second full 256-line flush follows immediately after done; exactly two done pulses.
- reset asserted at invadr=50 -> all outputs 0 immediately (asynchronously); no invwe after release (macro off).
- flushreq & swcreq same cycle with swcnext=0 while swc=0 -> one flush, swc remains 0, one done pulse.
- FLUSH_ON_RESET_EN defined, no requests -> stall=1 from first cycle after reset release, 256 invalidates, done pulse.
